// File: rtl/foc_adc_pkg.sv
// Shared types and helpers for the FOC ADC sample scheduler.
// State encoding, saturation limits and the 17-to-16-bit saturator.
package foc_adc_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_WAIT = 2'd2,
        S_PROC = 2'd3
    } state_t;

    localparam logic signed [16:0] SAT_MAX = 17'sd32767;
    localparam logic signed [16:0] SAT_MIN = -17'sd32768;

    function automatic logic [15:0] sat16(input logic signed [16:0] d);
        if (d > SAT_MAX) begin
            return 16'h7fff;
        end else if (d < SAT_MIN) begin
            return 16'h8000;
        end else begin
            return d[15:0];
        end
    endfunction

endpackage

// File: rtl/adc_offset_cal.sv
// One phase channel: calibration accumulator, zero-current offset
// register and saturated offset subtraction.
module adc_offset_cal
    import foc_adc_pkg::*;
#(
    parameter int CAL_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        acc_en,
    input  logic        acc_last,
    input  logic        run_en,
    input  logic [15:0] sample,
    output logic [15:0] cur
);

    localparam int AW = 16 + CAL_LOG2;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;
    logic signed [15:0]   off;
    logic signed [16:0]   diff;

    assign sum  = acc + {{CAL_LOG2{sample[15]}}, sample};
    assign diff = {sample[15], sample} - {off[15], off};

    // Accumulate calibration samples; restart after the last one or on recal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc_last ? '0 : sum;
        end
    end

    // Offset is the arithmetic mean: the top 16 bits of the full sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off <= '0;
        end else if (acc_en && acc_last) begin
            off <= sum[AW-1:CAL_LOG2];
        end
    end

    // Corrected current, held between run-mode conversions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= '0;
        end else if (run_en) begin
            cur <= sat16(diff);
        end
    end

endmodule

// File: rtl/adc_sample_sched.sv
// AD7606 conversion scheduler for the FOC current loop: decimated
// triggering, timeout supervision, offset calibration, run-mode output.
module adc_sample_sched
    import foc_adc_pkg::*;
#(
    parameter int DECIM    = 1,
    parameter int CAL_LOG2 = 4,
    parameter int TIMEOUT  = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        recal,
    input  logic        clr_fault,
    input  logic        pwm_sync,
    input  logic        adc_done,
    input  logic [15:0] adc_ch1,
    input  logic [15:0] adc_ch2,
    input  logic [15:0] adc_ch3,
    output logic        adc_en,
    output logic        adc_start,
    output logic [15:0] ia,
    output logic [15:0] ib,
    output logic [15:0] ic,
    output logic        sample_valid,
    output logic        cal_done,
    output logic        fault_timeout,
    output logic        overrun
);

    localparam logic [7:0]  DEC_LAST = 8'(DECIM - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [7:0]  CAL_LAST = 8'((1 << CAL_LOG2) - 1);

    state_t      state, state_n;
    logic [7:0]  dec_cnt;
    logic [7:0]  cal_cnt;
    logic [15:0] tmo_cnt;
    logic        recal_pend;
    logic [15:0] smp1, smp2, smp3;
    logic        go, take, tmo_hit;
    logic        arm_clr, proc_cal, proc_run, cal_last;

    assign arm_clr  = en && (state == S_ARM) && recal_pend;
    assign proc_cal = (state == S_PROC) && !cal_done;
    assign proc_run = (state == S_PROC) && cal_done;
    assign cal_last = (cal_cnt == CAL_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and per-cycle strobes; dropping en abandons everything.
    always_comb begin
        state_n = state;
        go      = 1'b0;
        take    = 1'b0;
        tmo_hit = 1'b0;
        if (!en) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: state_n = S_ARM;
                S_ARM: begin
                    if (pwm_sync && dec_cnt == DEC_LAST) begin
                        go      = 1'b1;
                        state_n = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (adc_done) begin
                        take    = 1'b1;
                        state_n = S_PROC;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_hit = 1'b1;
                        state_n = S_ARM;
                    end
                end
                S_PROC:  state_n = S_ARM;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Conversion sequencing: enable, start pulse, decimation, timeout, latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_en    <= 1'b0;
            adc_start <= 1'b0;
            dec_cnt   <= '0;
            tmo_cnt   <= '0;
            smp1      <= '0;
            smp2      <= '0;
            smp3      <= '0;
        end else begin
            adc_en    <= en;
            adc_start <= go;
            if (!en) begin
                dec_cnt <= '0;
            end else if (state == S_ARM && pwm_sync) begin
                dec_cnt <= go ? 8'd0 : dec_cnt + 8'd1;
            end
            if (go) begin
                tmo_cnt <= '0;
            end else if (state == S_WAIT) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
            if (take) begin
                smp1 <= adc_ch1;
                smp2 <= adc_ch2;
                smp3 <= adc_ch3;
            end
        end
    end

    // Sticky flags and recal request; a set beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_timeout <= 1'b0;
            overrun       <= 1'b0;
            recal_pend    <= 1'b0;
        end else begin
            if (tmo_hit) begin
                fault_timeout <= 1'b1;
            end else if (clr_fault) begin
                fault_timeout <= 1'b0;
            end
            if (en && state == S_WAIT && pwm_sync) begin
                overrun <= 1'b1;
            end else if (clr_fault) begin
                overrun <= 1'b0;
            end
            if (recal) begin
                recal_pend <= 1'b1;
            end else if (arm_clr) begin
                recal_pend <= 1'b0;
            end
        end
    end

    // Calibration progress and the run-mode output strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cal_done     <= 1'b0;
            cal_cnt      <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= proc_run;
            if (arm_clr) begin
                cal_done <= 1'b0;
                cal_cnt  <= '0;
            end else if (proc_cal) begin
                cal_done <= cal_last;
                cal_cnt  <= cal_last ? 8'd0 : cal_cnt + 8'd1;
            end
        end
    end

    adc_offset_cal #(.CAL_LOG2(CAL_LOG2)) u_cal_a (
        .clk(clk), .rst_n(rst_n), .clr(arm_clr), .acc_en(proc_cal),
        .acc_last(cal_last), .run_en(proc_run), .sample(smp1), .cur(ia)
    );

    adc_offset_cal #(.CAL_LOG2(CAL_LOG2)) u_cal_b (
        .clk(clk), .rst_n(rst_n), .clr(arm_clr), .acc_en(proc_cal),
        .acc_last(cal_last), .run_en(proc_run), .sample(smp2), .cur(ib)
    );

    adc_offset_cal #(.CAL_LOG2(CAL_LOG2)) u_cal_c (
        .clk(clk), .rst_n(rst_n), .clr(arm_clr), .acc_en(proc_cal),
        .acc_last(cal_last), .run_en(proc_run), .sample(smp3), .cur(ic)
    );

endmodule

// File: tb/tb_adc_sample_sched.sv
// Self-checking bench for adc_sample_sched against a transaction-level
// model of decimation, calibration averaging and saturated correction.
module tb_adc_sample_sched;

    localparam int DECIM    = 3;
    localparam int CAL_LOG2 = 2;
    localparam int TIMEOUT  = 10;
    localparam int NCAL     = 1 << CAL_LOG2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        recal = 1'b0;
    logic        clr_fault = 1'b0;
    logic        pwm_sync = 1'b0;
    logic        adc_done = 1'b0;
    logic [15:0] adc_ch1 = '0;
    logic [15:0] adc_ch2 = '0;
    logic [15:0] adc_ch3 = '0;
    logic        adc_en, adc_start, sample_valid, cal_done;
    logic        fault_timeout, overrun;
    logic [15:0] ia, ib, ic;

    int n_cmp = 0;
    int n_err = 0;

    int m_dec = 0;
    bit m_cal = 1'b0;
    bit m_fault = 1'b0;
    bit m_ovr = 1'b0;
    int m_off[3];
    int m_cur[3];
    int q1[$];
    int q2[$];
    int q3[$];

    adc_sample_sched #(
        .DECIM(DECIM), .CAL_LOG2(CAL_LOG2), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .recal(recal),
        .clr_fault(clr_fault), .pwm_sync(pwm_sync), .adc_done(adc_done),
        .adc_ch1(adc_ch1), .adc_ch2(adc_ch2), .adc_ch3(adc_ch3),
        .adc_en(adc_en), .adc_start(adc_start), .ia(ia), .ib(ib), .ic(ic),
        .sample_valid(sample_valid), .cal_done(cal_done),
        .fault_timeout(fault_timeout), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int rand16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    function automatic int floor_mean(input int s);
        int r;
        r = ((s % NCAL) + NCAL) % NCAL;
        return (s - r) / NCAL;
    endfunction

    // Issue syncs until the model expects a start; check each start slot.
    task automatic issue_syncs();
        int need;
        need = DECIM - m_dec;
        for (int i = 0; i < need; i++) begin
            pwm_sync = 1'b1;
            tick();
            pwm_sync = 1'b0;
            n_cmp++;
            if (adc_start !== (i == need - 1)) begin
                n_err++;
                $display("FAIL start_slot: sync %0d adc_start=%b want %b",
                         i, adc_start, (i == need - 1));
            end
        end
        m_dec = 0;
    endtask

    // One full conversion: trigger, respond after dly cycles, check result.
    task automatic conv(input int c1, input int c2, input int c3,
                        input int dly, input int sync_k);
        int c[3];
        int s;
        bit was_cal;
        c = '{c1, c2, c3};
        issue_syncs();
        for (int k = 0; k < dly; k++) begin
            if (k == 1) begin
                n_cmp++;
                if (adc_start !== 1'b0) begin
                    n_err++;
                    $display("FAIL start_width: adc_start=%b want 0", adc_start);
                end
            end
            pwm_sync = (k == sync_k);
            if (k == sync_k) m_ovr = 1'b1;
            tick();
            pwm_sync = 1'b0;
        end
        adc_done = 1'b1;
        adc_ch1 = c1[15:0];
        adc_ch2 = c2[15:0];
        adc_ch3 = c3[15:0];
        pwm_sync = (sync_k == dly);
        if (sync_k == dly) m_ovr = 1'b1;
        tick();
        adc_done = 1'b0;
        pwm_sync = 1'b0;
        n_cmp++;
        if (sample_valid !== 1'b0) begin
            n_err++;
            $display("FAIL valid_early: sample_valid=%b want 0", sample_valid);
        end
        n_cmp++;
        if (overrun !== m_ovr) begin
            n_err++;
            $display("FAIL overrun: got %b want %b", overrun, m_ovr);
        end
        was_cal = m_cal;
        if (m_cal) begin
            for (int i = 0; i < 3; i++) m_cur[i] = sat(c[i] - m_off[i]);
        end else begin
            q1.push_back(c1);
            q2.push_back(c2);
            q3.push_back(c3);
            if (q1.size() == NCAL) begin
                s = 0; foreach (q1[j]) s += q1[j]; m_off[0] = floor_mean(s);
                s = 0; foreach (q2[j]) s += q2[j]; m_off[1] = floor_mean(s);
                s = 0; foreach (q3[j]) s += q3[j]; m_off[2] = floor_mean(s);
                m_cal = 1'b1;
                q1.delete(); q2.delete(); q3.delete();
            end
        end
        tick();
        n_cmp++;
        if (sample_valid !== was_cal) begin
            n_err++;
            $display("FAIL valid: sample_valid=%b want %b", sample_valid, was_cal);
        end
        if (was_cal) begin
            n_cmp++;
            if (ia !== m_cur[0][15:0] || ib !== m_cur[1][15:0] ||
                ic !== m_cur[2][15:0]) begin
                n_err++;
                $display("FAIL currents: got %0d %0d %0d want %0d %0d %0d",
                         $signed(ia), $signed(ib), $signed(ic),
                         m_cur[0], m_cur[1], m_cur[2]);
            end
        end
        n_cmp++;
        if (cal_done !== m_cal || fault_timeout !== m_fault) begin
            n_err++;
            $display("FAIL flags: cal_done=%b fault=%b want %b %b",
                     cal_done, fault_timeout, m_cal, m_fault);
        end
        tick();
        n_cmp++;
        if (sample_valid !== 1'b0) begin
            n_err++;
            $display("FAIL valid_width: sample_valid=%b want 0", sample_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({adc_en, adc_start, sample_valid, cal_done, fault_timeout,
             overrun} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 000000",
                     {adc_en, adc_start, sample_valid, cal_done,
                      fault_timeout, overrun});
        end
        n_cmp++;
        if ({ia, ib, ic} !== 48'h0) begin
            n_err++;
            $display("FAIL reset_currents: got %h %h %h want 0", ia, ib, ic);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (adc_en !== 1'b0) begin
            n_err++;
            $display("FAIL adc_en_idle: got %b want 0", adc_en);
        end
    endtask

    task automatic test_calibration();
        int ch1[4];
        ch1 = '{100, 102, 98, 100};
        en = 1'b1;
        tick();
        n_cmp++;
        if (adc_en !== 1'b1) begin
            n_err++;
            $display("FAIL adc_en_delay: got %b want 1", adc_en);
        end
        for (int i = 0; i < 4; i++) begin
            conv(ch1[i], rand16(), rand16(), int'($urandom_range(0, TIMEOUT - 1)), -1);
        end
        conv(1100, rand16(), rand16(), 0, -1);
        n_cmp++;
        if (ia !== 16'd1000) begin
            n_err++;
            $display("FAIL run_ia: got %0d want 1000", $signed(ia));
        end
    endtask

    task automatic test_random_run();
        for (int i = 0; i < 16; i++) begin
            conv(rand16(), rand16(), rand16(), int'($urandom_range(0, TIMEOUT - 1)), -1);
        end
        conv(rand16(), rand16(), rand16(), TIMEOUT - 1, -1);
    endtask

    task automatic test_saturation();
        int ch1[4];
        ch1 = '{-199, -201, -200, -200};
        recal = 1'b1;
        tick();
        recal = 1'b0;
        tick();
        m_cal = 1'b0;
        q1.delete(); q2.delete(); q3.delete();
        n_cmp++;
        if (cal_done !== 1'b0) begin
            n_err++;
            $display("FAIL recal_clear: cal_done=%b want 0", cal_done);
        end
        for (int i = 0; i < 4; i++) begin
            conv(ch1[i], 30000, rand16(), int'($urandom_range(0, TIMEOUT - 1)), -1);
        end
        conv(32767, -32768, rand16(), 1, -1);
        n_cmp++;
        if (ia !== 16'h7fff || ib !== 16'h8000) begin
            n_err++;
            $display("FAIL saturate: ia=%h ib=%h want 7fff 8000", ia, ib);
        end
    endtask

    task automatic test_decimation();
        int nstart;
        int e;
        int v;
        nstart = 0;
        for (int s = 1; s <= 9; s++) begin
            pwm_sync = 1'b1;
            tick();
            pwm_sync = 1'b0;
            n_cmp++;
            if (adc_start !== (s % DECIM == 0)) begin
                n_err++;
                $display("FAIL decim_slot: sync %0d adc_start=%b", s, adc_start);
            end
            if (adc_start === 1'b1) begin
                nstart++;
                v = rand16();
                e = sat(v - m_off[0]);
                m_cur[0] = e;
                adc_done = 1'b1;
                adc_ch1 = v[15:0];
                tick();
                adc_done = 1'b0;
                tick();
                m_cur[1] = sat(int'($signed(adc_ch2)) - m_off[1]);
                m_cur[2] = sat(int'($signed(adc_ch3)) - m_off[2]);
                n_cmp++;
                if (sample_valid !== 1'b1 || ia !== e[15:0]) begin
                    n_err++;
                    $display("FAIL decim_sample: valid=%b ia=%0d want 1 %0d",
                             sample_valid, $signed(ia), e);
                end
            end
        end
        n_cmp++;
        if (nstart !== 3) begin
            n_err++;
            $display("FAIL decim_count: %0d starts want 3", nstart);
        end
    endtask

    task automatic test_timeout();
        issue_syncs();
        for (int k = 0; k <= TIMEOUT; k++) begin
            n_cmp++;
            if (fault_timeout !== (k == TIMEOUT)) begin
                n_err++;
                $display("FAIL timeout_edge: k=%0d fault=%b want %b",
                         k, fault_timeout, (k == TIMEOUT));
            end
            if (k < TIMEOUT) begin
                clr_fault = (k == TIMEOUT - 1);
                tick();
                clr_fault = 1'b0;
            end
        end
        m_fault = 1'b1;
        adc_done = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            adc_done = 1'b0;
            n_cmp++;
            if (sample_valid !== 1'b0) begin
                n_err++;
                $display("FAIL timeout_late_done: sample_valid=%b want 0", sample_valid);
            end
        end
        conv(rand16(), rand16(), rand16(), 2, -1);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        m_fault = 1'b0;
        n_cmp++;
        if (fault_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_clear: fault=%b want 0", fault_timeout);
        end
    endtask

    task automatic test_overrun();
        conv(rand16(), rand16(), rand16(), 4, 2);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        m_ovr = 1'b0;
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_clear: overrun=%b want 0", overrun);
        end
        conv(rand16(), rand16(), rand16(), 3, 3);
        conv(rand16(), rand16(), rand16(), 1, -1);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic test_en_drop();
        issue_syncs();
        tick();
        tick();
        en = 1'b0;
        tick();
        n_cmp++;
        if (adc_en !== 1'b0 || adc_start !== 1'b0) begin
            n_err++;
            $display("FAIL en_drop: adc_en=%b adc_start=%b want 0 0", adc_en, adc_start);
        end
        adc_done = 1'b1;
        adc_ch1 = 16'h1234;
        for (int k = 0; k < 3; k++) begin
            tick();
            adc_done = 1'b0;
            n_cmp++;
            if (sample_valid !== 1'b0 || ia !== m_cur[0][15:0]) begin
                n_err++;
                $display("FAIL en_drop_late_done: valid=%b ia=%0d want 0 %0d",
                         sample_valid, $signed(ia), m_cur[0]);
            end
        end
        for (int k = 0; k < DECIM; k++) begin
            pwm_sync = 1'b1;
            tick();
            pwm_sync = 1'b0;
            n_cmp++;
            if (adc_start !== 1'b0) begin
                n_err++;
                $display("FAIL idle_start: adc_start=%b want 0", adc_start);
            end
        end
        en = 1'b1;
        tick();
        n_cmp++;
        if (adc_en !== 1'b1 || cal_done !== m_cal) begin
            n_err++;
            $display("FAIL reenable: adc_en=%b cal_done=%b want 1 %b",
                     adc_en, cal_done, m_cal);
        end
        pwm_sync = 1'b1;
        tick();
        pwm_sync = 1'b0;
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        m_dec = 0;
        conv(rand16(), rand16(), rand16(), int'($urandom_range(0, TIMEOUT - 1)), -1);
    endtask

    initial begin
        test_reset();
        test_calibration();
        test_random_run();
        test_saturation();
        test_random_run();
        test_decimation();
        test_timeout();
        test_overrun();
        test_en_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adc_sample_sched.md
Name: adc_sample_sched

Overview:
Sequences the AD7606 controller for the FOC current loop. It triggers a conversion on every DECIM-th PWM-centre sync and supervises completion with a timeout. At enable and on request, it calibrates per-phase zero-current offsets by averaging 2^CAL_LOG2 conversions. In run mode it outputs offset-corrected, saturated signed phase currents with a one-cycle valid strobe to the Clarke/Park stage.

Parameters:
DECIM, 1, PWM syncs per conversion (1..255)
CAL_LOG2, 4, log2 of calibration sample count (1..8)
TIMEOUT, 500, clk cycles allowed from adc_start to adc_done (2..65535)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  scheduler enable (level)
recal  in  1  pulse: discard offsets, recalibrate
clr_fault  in  1  pulse: clear sticky flags
pwm_sync  in  1  one-cycle PWM centre pulse
adc_done  in  1  one-cycle conversion-complete pulse from ADC controller
adc_ch1, adc_ch2, adc_ch3  in  16  two's-complement raw samples, stable when adc_done=1
adc_en  out  1  ADC controller enable
adc_start  out  1  one-cycle conversion request
ia, ib, ic  out  16  signed corrected phase currents
sample_valid  out  1  one-cycle strobe, ia/ib/ic updated
cal_done  out  1  offsets valid
fault_timeout  out  1  sticky: adc_done missing within TIMEOUT
overrun  out  1  sticky: pwm_sync arrived while a conversion was outstanding

Behaviour:
- Reset: every output is 0; state is IDLE; offsets, accumulators, decimation counter, calibration counter, timeout counter and pending-recal flag are all 0.
- adc_en is en registered, giving one cycle of delay.
- States: IDLE, ARM, WAIT, PROC.
- IDLE: when en=1, go to ARM.
- ARM: when recal is pending, clear cal_done, the accumulators and cal_cnt, then clear the pending flag.
- ARM: each pwm_sync increments dec_cnt. When the sync arrives with dec_cnt==DECIM-1, set dec_cnt to 0, assert adc_start for exactly the next cycle, clear the timeout counter and go to WAIT.
- ARM: adc_done is ignored.
- WAIT: the timeout counter increments every cycle.
  - On adc_done: latch adc_ch1..3 and go to PROC.
  - When the counter reaches TIMEOUT-1 without adc_done: set fault_timeout, go to ARM, produce no sample and leave calibration untouched.
  - pwm_sync in WAIT sets overrun and is not counted toward decimation.
- PROC (one cycle), when cal_done=0:
  - acc_n += sign-extended sample; accumulators are 16+CAL_LOG2 bits signed.
  - cal_cnt++.
  - When cal_cnt==2^CAL_LOG2-1: off_n <= (acc_n + sample) >>> CAL_LOG2 (arithmetic shift), set cal_done, clear acc and cal_cnt.
- PROC, when cal_done=1:
  - Compute 17-bit diff = ch_n - off_n.
  - Saturate to [-32768, 32767].
  - Register the results to ia/ib/ic and pulse sample_valid.
- PROC always returns to ARM.
- Latency: adc_done high in cycle c gives sample_valid high in cycle c+2. Outputs hold their values between strobes.
- en deasserted in any state: next state is IDLE; adc_start drops; any outstanding conversion is abandoned and its late adc_done is ignored; dec_cnt clears. Offsets, cal_done and sticky flags are retained.
- recal is captured into the pending flag in any state and applied on the next ARM. A PROC already in progress completes using the old offsets.
- clr_fault clears both sticky flags. When a flag is set and cleared in the same cycle, set wins.
- Simultaneous pwm_sync and adc_done in WAIT: adc_done is taken to PROC and overrun is also set.

Decomposition:
- Shared package foc_adc_pkg holds:
  - state encoding localparams;
  - SAT_MAX/SAT_MIN constants;
  - function sat16 (17-bit signed to 16-bit saturated).
- One natural sub-module, adc_offset_cal, covers a single channel: accumulator, offset register and saturated subtraction. It is instantiated three times and shares cal_cnt and control from the top.

Test Plan:
- Calibration (CAL_LOG2=2, DECIM=1): 4 syncs with adc_done returning ch1=100, 102, 98, 100 → cal_done=1 after the 4th PROC; off1=100; no sample_valid during calibration.
- Run: ch1=1100 with off1=100 → ia=1000, with sample_valid exactly 2 cycles after adc_done. Saturation case: ch1=32767 with off1=-200 → ia=32767.
- Decimation (DECIM=3): 9 pwm_sync pulses → exactly 3 adc_start pulses, on syncs 3, 6 and 9.
- Timeout (TIMEOUT=10): adc_start with no adc_done → fault_timeout=1 at cycle 10, state returns to ARM, and the next sync restarts normally. clr_fault then clears the flag.
- Overrun: pwm_sync during WAIT → overrun=1, dec_cnt unchanged. The same-cycle adc_done is still processed.
- en drop in WAIT, then a late adc_done → no sample_valid, state IDLE, adc_en=0 one cycle later. Re-enable → first start on the next DECIM-th sync.
